// File: rtl/ascon_pkg.sv
// Shared Ascon-128 definitions: constants, FSM state encoding and the round-constant helper.
package ascon_pkg;

   localparam int          STATE_W  = 320;
   localparam int          CNT_W    = 4;
   localparam logic [63:0] ASCON_IV = 64'h80400c0600000000;
   localparam logic [63:0] PAD      = 64'h8000000000000000;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_INIT,
      ST_AD_WAIT,
      ST_AD_PERM,
      ST_AD_PAD,
      ST_CT_WAIT,
      ST_CT_OUT,
      ST_CT_PERM,
      ST_FINAL,
      ST_DONE
   } state_t;

   // Round i of the 12-round schedule; the 6-round permutation runs i = 6..11.
   function automatic logic [7:0] rc(input logic [CNT_W-1:0] i);
      logic [7:0] w_i;
      w_i = 8'(i);
      return 8'hf0 - w_i * 8'h0f;
   endfunction

endpackage

// File: rtl/ascon_round_comb.sv
// One combinational Ascon permutation round: constant addition, bitsliced S-box, linear diffusion.
module ascon_round_comb
   import ascon_pkg::*;
(
   input  logic [STATE_W-1:0] i_state,
   input  logic [7:0]         i_rc,
   output logic [STATE_W-1:0] o_state
);

   logic [63:0] w_x0, w_x1, w_x2, w_x3, w_x4;
   logic [63:0] w_t0, w_t1, w_t2, w_t3, w_t4;

   function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
      return (v >> n) | (v << (64 - n));
   endfunction

   always_comb begin
      w_x0 = i_state[319:256];
      w_x1 = i_state[255:192];
      w_x2 = i_state[191:128] ^ {56'd0, i_rc};
      w_x3 = i_state[127:64];
      w_x4 = i_state[63:0];

      // S-box applied to all 64 five-bit columns at once
      w_x0 = w_x0 ^ w_x4;
      w_x4 = w_x4 ^ w_x3;
      w_x2 = w_x2 ^ w_x1;
      w_t0 = ~w_x0 & w_x1;
      w_t1 = ~w_x1 & w_x2;
      w_t2 = ~w_x2 & w_x3;
      w_t3 = ~w_x3 & w_x4;
      w_t4 = ~w_x4 & w_x0;
      w_x0 = w_x0 ^ w_t1;
      w_x1 = w_x1 ^ w_t2;
      w_x2 = w_x2 ^ w_t3;
      w_x3 = w_x3 ^ w_t4;
      w_x4 = w_x4 ^ w_t0;
      w_x1 = w_x1 ^ w_x0;
      w_x0 = w_x0 ^ w_x4;
      w_x3 = w_x3 ^ w_x2;
      w_x2 = ~w_x2;

      o_state = {w_x0 ^ ror64(w_x0, 19) ^ ror64(w_x0, 28),
                 w_x1 ^ ror64(w_x1, 61) ^ ror64(w_x1, 39),
                 w_x2 ^ ror64(w_x2, 1)  ^ ror64(w_x2, 6),
                 w_x3 ^ ror64(w_x3, 10) ^ ror64(w_x3, 17),
                 w_x4 ^ ror64(w_x4, 7)  ^ ror64(w_x4, 41)};
   end

endmodule

// File: rtl/ascon128_dec_core.sv
// Iterative Ascon-128 decryption core: one round per clock, streams AD and ciphertext,
// releases plaintext per beat and reports tag verification at the end.
module ascon128_dec_core
   import ascon_pkg::*;
#(
   parameter logic [63:0] IV = ASCON_IV
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key,
   input  logic [127:0] nonce,
   input  logic [127:0] tag_in,
   input  logic         has_ad,
   input  logic         has_ct,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [63:0]  in_data,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [63:0]  out_data,
   output logic         busy,
   output logic         done,
   output logic         tag_ok
);

   state_t               r_state, w_next, w_ct_entry;
   logic [CNT_W-1:0]     r_cnt, w_cnt_next;
   logic [STATE_W-1:0]   r_s, w_rin, w_rout, w_rpost;
   logic [127:0]         r_key, r_tag, w_tag;
   logic                 r_has_ad, r_has_ct, r_last, r_tag_ok;
   logic [63:0]          r_out;
   logic [7:0]           w_rc;
   logic                 w_round_st, w_last_rnd;

   assign w_rc     = rc(r_cnt);
   assign out_data = r_out;
   assign tag_ok   = r_tag_ok;

   ascon_round_comb u_round (
      .i_state (w_rin),
      .i_rc    (w_rc),
      .o_state (w_rout)
   );

   // Domain-separation and key injections folded into the round input/output
   always_comb begin
      w_last_rnd = (r_cnt == CNT_W'(11));
      w_round_st = (r_state == ST_INIT) || (r_state == ST_AD_PERM) || (r_state == ST_AD_PAD) ||
                   (r_state == ST_CT_PERM) || (r_state == ST_FINAL);

      w_rin = r_s;
      if (r_state == ST_AD_PAD && r_cnt == CNT_W'(6)) begin
         w_rin[319:256] = r_s[319:256] ^ PAD;
      end
      if (r_state == ST_FINAL && r_cnt == CNT_W'(0)) begin
         w_rin[319:256] = r_s[319:256] ^ PAD;
         w_rin[255:192] = r_s[255:192] ^ r_key[127:64];
         w_rin[191:128] = r_s[191:128] ^ r_key[63:0];
      end

      w_rpost = w_rout;
      if (w_last_rnd && r_state == ST_INIT) begin
         w_rpost[127:64] = w_rout[127:64] ^ r_key[127:64];
         w_rpost[63:0]   = w_rout[63:0] ^ r_key[63:0] ^ {63'd0, ~r_has_ad};
      end
      if (w_last_rnd && r_state == ST_AD_PAD) begin
         w_rpost[0] = ~w_rout[0];
      end

      w_tag = {w_rout[127:64] ^ r_key[127:64], w_rout[63:0] ^ r_key[63:0]};
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_ct_entry = r_has_ct ? ST_CT_WAIT : ST_FINAL;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = (r_state != ST_IDLE);
      done       = 1'b0;
      case (r_state)
         ST_IDLE:    if (start) w_next = ST_INIT;
         ST_INIT:    if (w_last_rnd) w_next = r_has_ad ? ST_AD_WAIT : w_ct_entry;
         ST_AD_WAIT: begin
            in_ready = 1'b1;
            if (in_valid) w_next = ST_AD_PERM;
         end
         ST_AD_PERM: if (w_last_rnd) w_next = r_last ? ST_AD_PAD : ST_AD_WAIT;
         ST_AD_PAD:  if (w_last_rnd) w_next = w_ct_entry;
         ST_CT_WAIT: begin
            in_ready = 1'b1;
            if (in_valid) w_next = ST_CT_OUT;
         end
         ST_CT_OUT: begin
            out_valid = 1'b1;
            if (out_ready) w_next = ST_CT_PERM;
         end
         ST_CT_PERM: if (w_last_rnd) w_next = r_last ? ST_FINAL : ST_CT_WAIT;
         ST_FINAL:   if (w_last_rnd) w_next = ST_DONE;
         ST_DONE: begin
            done   = 1'b1;
            w_next = ST_IDLE;
         end
         default:    w_next = ST_IDLE;
      endcase

      // p12 phases count 0..11, p6 phases count 6..11
      w_cnt_next = r_cnt;
      if (w_round_st) begin
         if (w_last_rnd) w_cnt_next = (w_next == ST_FINAL) ? CNT_W'(0) : CNT_W'(6);
         else            w_cnt_next = r_cnt + CNT_W'(1);
      end
      if (r_state == ST_IDLE) w_cnt_next = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s      <= '0;
         r_cnt    <= '0;
         r_key    <= '0;
         r_tag    <= '0;
         r_has_ad <= 1'b0;
         r_has_ct <= 1'b0;
         r_last   <= 1'b0;
         r_out    <= '0;
         r_tag_ok <= 1'b0;
      end else begin
         r_cnt <= w_cnt_next;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_key    <= key;
                  r_tag    <= tag_in;
                  r_has_ad <= has_ad;
                  r_has_ct <= has_ct;
                  r_s      <= {IV, key, nonce};
                  r_tag_ok <= 1'b0;
               end
            end
            ST_AD_WAIT: begin
               if (in_valid) begin
                  r_s[319:256] <= r_s[319:256] ^ in_data;
                  r_last       <= in_last;
               end
            end
            ST_CT_WAIT: begin
               if (in_valid) begin
                  r_out        <= r_s[319:256] ^ in_data;
                  r_s[319:256] <= in_data;
                  r_last       <= in_last;
               end
            end
            ST_INIT, ST_AD_PERM, ST_AD_PAD, ST_CT_PERM: r_s <= w_rpost;
            ST_FINAL: begin
               r_s <= w_rpost;
               if (w_last_rnd) r_tag_ok <= (w_tag == r_tag);
            end
            default: ;
         endcase
      end
   end

endmodule
